// File: rtl/trigger_pkg.sv
// Shared constants for the trigger engine: FSM encoding, edge-type codes and
// source-select codes.
package trigger_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMING  = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  localparam logic [1:0] EDGE_POS    = 2'b00;
  localparam logic [1:0] EDGE_NEG    = 2'b01;
  localparam logic [1:0] EDGE_EITHER = 2'b10;
  localparam logic [1:0] EDGE_RSVD   = 2'b11;

  // Select 0 disables triggering; channels start at 1; EXT is N_CH+1.
  localparam int SRC_NONE = 0;
  localparam int SRC_CH0  = 1;

  function automatic logic pos_enabled(input logic [1:0] e);
    return (e == EDGE_POS) || (e == EDGE_EITHER) || (e == EDGE_RSVD);
  endfunction

  function automatic logic neg_enabled(input logic [1:0] e);
    return (e == EDGE_NEG) || (e == EDGE_EITHER);
  endfunction

endpackage

// File: rtl/trigger_level_cmp.sv
// Saturating hysteresis thresholds around the trigger level and the four
// sample comparisons the FSM needs.
module trigger_level_cmp #(
  parameter int BITS_ADC = 8
) (
  input  logic [BITS_ADC-1:0] s,
  input  logic [BITS_ADC-1:0] level,
  input  logic [BITS_ADC-1:0] hyst,
  output logic                above_high,
  output logic                below_low,
  output logic                ge_level,
  output logic                le_level
);

  logic [BITS_ADC:0]   sum;
  logic [BITS_ADC-1:0] low, high;

  assign sum  = {1'b0, level} + {1'b0, hyst};
  assign high = sum[BITS_ADC] ? {BITS_ADC{1'b1}} : sum[BITS_ADC-1:0];
  assign low  = (level >= hyst) ? level - hyst : '0;

  assign above_high = s > high;
  assign below_low  = s < low;
  assign ge_level   = s >= level;
  assign le_level   = s <= level;

endmodule

// File: rtl/trigger_engine.sv
// Edge trigger FSM: latches configuration on arm, qualifies an edge through a
// hysteresis band, pulses triggered, then holds off for a number of strobes.
module trigger_engine
  import trigger_pkg::*;
#(
  parameter  int BITS_ADC  = 8,
  parameter  int N_CH      = 2,
  parameter  int HOLDOFF_W = 16,
  localparam int SEL_W     = $clog2(N_CH + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*BITS_ADC-1:0] ch_in,
  input  logic [N_CH-1:0]          ch_rdy,
  input  logic                     ext_in,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [SEL_W-1:0]         trigger_source_sel,
  input  logic [1:0]               trigger_edge_type,
  input  logic [BITS_ADC-1:0]      trigger_value,
  input  logic [BITS_ADC-1:0]      hysteresis,
  input  logic [HOLDOFF_W-1:0]     holdoff,
  input  logic                     auto_rearm,
  output logic                     armed,
  output logic                     triggered,
  output logic                     trigger_neg,
  output logic                     busy
);

  logic [1:0]           state;
  logic                 pos_ok, neg_ok;
  logic [HOLDOFF_W-1:0] hold_cnt;

  logic [SEL_W-1:0]     cfg_src;
  logic [1:0]           cfg_edge;
  logic [BITS_ADC-1:0]  cfg_level, cfg_hyst;
  logic [HOLDOFF_W-1:0] cfg_holdoff;
  logic                 cfg_auto;

  logic [BITS_ADC-1:0]  s, lvl, hy;
  logic                 strobe;
  logic                 above_high, below_low, ge_level, le_level;
  logic                 arm_pos, arm_neg, fire_pos, fire_neg;

  // Source mux; unmatched selects (none / out of range) never strobe.
  always_comb begin
    s      = '0;
    strobe = 1'b0;
    lvl    = cfg_level;
    hy     = cfg_hyst;
    for (int k = 0; k < N_CH; k++) begin
      if (cfg_src == SEL_W'(k + SRC_CH0)) begin
        s      = ch_in[k*BITS_ADC +: BITS_ADC];
        strobe = ch_rdy[k];
      end
    end
    if (cfg_src == SEL_W'(N_CH + 1)) begin
      s      = {BITS_ADC{ext_in}};
      strobe = |ch_rdy;
      lvl    = BITS_ADC'(1) << (BITS_ADC - 1);
      hy     = '0;
    end
    if (cfg_src == SEL_W'(SRC_NONE)) strobe = 1'b0;
  end

  trigger_level_cmp #(.BITS_ADC(BITS_ADC)) u_cmp (
    .s          (s),
    .level      (lvl),
    .hyst       (hy),
    .above_high (above_high),
    .below_low  (below_low),
    .ge_level   (ge_level),
    .le_level   (le_level)
  );

  assign arm_pos  = pos_enabled(cfg_edge) & below_low;
  assign arm_neg  = neg_enabled(cfg_edge) & above_high;
  assign fire_pos = strobe & pos_ok & ge_level;
  assign fire_neg = strobe & neg_ok & le_level;

  assign armed = (state == ST_ARMING) || (state == ST_WAIT);
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pos_ok      <= 1'b0;
      neg_ok      <= 1'b0;
      hold_cnt    <= '0;
      triggered   <= 1'b0;
      trigger_neg <= 1'b0;
      cfg_src     <= '0;
      cfg_edge    <= '0;
      cfg_level   <= '0;
      cfg_hyst    <= '0;
      cfg_holdoff <= '0;
      cfg_auto    <= 1'b0;
    end else begin
      triggered   <= 1'b0;
      trigger_neg <= 1'b0;
      if (abort) begin
        state    <= ST_IDLE;
        pos_ok   <= 1'b0;
        neg_ok   <= 1'b0;
        hold_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: if (arm) begin
            cfg_src     <= trigger_source_sel;
            cfg_edge    <= trigger_edge_type;
            cfg_level   <= trigger_value;
            cfg_hyst    <= hysteresis;
            cfg_holdoff <= holdoff;
            cfg_auto    <= auto_rearm;
            state       <= ST_ARMING;
          end
          // Flags only move together with the state so idle strobes are inert.
          ST_ARMING: if (strobe && (arm_pos || arm_neg)) begin
            pos_ok <= arm_pos;
            neg_ok <= arm_neg;
            state  <= ST_WAIT;
          end
          ST_WAIT: if (fire_pos || fire_neg) begin
            triggered   <= 1'b1;
            trigger_neg <= ~fire_pos;
            pos_ok      <= 1'b0;
            neg_ok      <= 1'b0;
            hold_cnt    <= cfg_holdoff;
            state       <= ST_HOLDOFF;
          end
          ST_HOLDOFF: begin
            if (hold_cnt == '0) state <= cfg_auto ? ST_ARMING : ST_IDLE;
            else if (strobe)    hold_cnt <= hold_cnt - 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trigger_engine.sv
// Directed bench for trigger_engine with hand-computed expectations.
module tb_trigger_engine;
  localparam int B = 8, NC = 2, HW = 16, SW = $clog2(NC + 2);

  logic          clk = 1'b0, rst = 1'b1;
  logic [NC*B-1:0] ch_in = '0;
  logic [NC-1:0] ch_rdy = '0;
  logic          ext_in = 1'b0, arm = 1'b0, abort = 1'b0, auto_rearm = 1'b0;
  logic [SW-1:0] src = '0;
  logic [1:0]    edge_t = '0;
  logic [B-1:0]  tval = '0, hyst = '0;
  logic [HW-1:0] hold = '0;
  logic          armed, triggered, trigger_neg, busy;
  int            n_chk = 0, n_fail = 0;

  trigger_engine #(.BITS_ADC(B), .N_CH(NC), .HOLDOFF_W(HW)) dut (
    .clk(clk), .rst(rst), .ch_in(ch_in), .ch_rdy(ch_rdy), .ext_in(ext_in),
    .arm(arm), .abort(abort), .trigger_source_sel(src),
    .trigger_edge_type(edge_t), .trigger_value(tval), .hysteresis(hyst),
    .holdoff(hold), .auto_rearm(auto_rearm), .armed(armed),
    .triggered(triggered), .trigger_neg(trigger_neg), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic strb(input int ch, input logic [7:0] v);
    ch_in[ch*B +: B] = v; ch_rdy[ch] = 1'b1; cyc(); ch_rdy = '0;
  endtask

  task automatic ext_strb(input logic e);
    ext_in = e; ch_rdy[1] = 1'b1; cyc(); ch_rdy = '0;
  endtask

  task automatic setcfg(input logic [SW-1:0] sr, input logic [1:0] e, input logic [7:0] l,
                        input logic [7:0] h, input logic [HW-1:0] ho, input logic au);
    src = sr; edge_t = e; tval = l; hyst = h; hold = ho; auto_rearm = au;
  endtask

  task automatic do_arm();
    arm = 1'b1; cyc(); arm = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; cyc(); abort = 1'b0;
  endtask

  initial begin
    // reset
    cyc(); cyc();
    chk("rst_armed", armed, 0); chk("rst_trig", triggered, 0);
    chk("rst_neg", trigger_neg, 0); chk("rst_busy", busy, 0);
    rst = 1'b0; cyc();
    chk("idle_busy", busy, 0);

    // CH1 positive, 0x60 then 0x85; config changes after arm are ignored
    setcfg(1, 2'b00, 8'h80, 8'h10, 0, 0);
    do_arm();
    chk("p_armed", armed, 1); chk("p_busy", busy, 1);
    tval = 8'hF0; hyst = 8'h00;
    strb(1, 8'h10);                       // other channel: no effect
    strb(0, 8'h60);
    chk("p_notrig", triggered, 0);
    strb(0, 8'h85);
    chk("p_trig", triggered, 1); chk("p_neg", trigger_neg, 0);
    chk("p_hold_armed", armed, 0); chk("p_hold_busy", busy, 1);
    cyc();
    chk("p_pulse1", triggered, 0); chk("p_idle", busy, 0);

    // 0x75 is inside the band: no arm, no trigger
    setcfg(1, 2'b00, 8'h80, 8'h10, 0, 0);
    do_arm();
    strb(0, 8'h75);
    strb(0, 8'h85);
    chk("band_notrig", triggered, 0); chk("band_armed", armed, 1);
    do_abort();
    chk("band_abort", busy, 0);

    // EXT negative; trigger_value 0xFF would never arm unless the forced level is used
    setcfg(3, 2'b01, 8'hFF, 8'h00, 0, 0);
    do_arm();
    ext_strb(1'b0); chk("ext_s0", triggered, 0);
    ext_strb(1'b1); chk("ext_s1", triggered, 0);
    ext_strb(1'b0); chk("ext_fire", triggered, 1); chk("ext_neg", trigger_neg, 1);
    ext_strb(1'b0); chk("ext_once", triggered, 0);
    cyc();

    // either edge, auto rearm, holdoff 3
    setcfg(1, 2'b10, 8'h80, 8'h10, 3, 1);
    do_arm();
    strb(0, 8'h60);
    strb(0, 8'h90);
    chk("ho_trig", triggered, 1); chk("ho_neg", trigger_neg, 0); chk("ho_armed0", armed, 0);
    strb(0, 8'h60); chk("ho_s1", armed, 0);
    strb(0, 8'h90); chk("ho_s2", armed, 0); chk("ho_s2_trig", triggered, 0);
    strb(0, 8'h60); chk("ho_s3", armed, 0);
    cyc();          chk("ho_rearmed", armed, 1);
    strb(0, 8'hA0);
    strb(0, 8'h70);
    chk("ho_negtrig", triggered, 1); chk("ho_negflag", trigger_neg, 1);
    do_abort();

    // holdoff 0 with auto rearm: armed back one cycle after the pulse
    setcfg(1, 2'b00, 8'h80, 8'h10, 0, 1);
    do_arm();
    strb(0, 8'h60); strb(0, 8'h85);
    chk("h0_trig", triggered, 1); chk("h0_armed0", armed, 0);
    cyc();
    chk("h0_armed1", armed, 1);
    do_abort();

    // high threshold saturates at 0xFF: never arms for negative edges
    setcfg(1, 2'b01, 8'hF8, 8'h10, 0, 0);
    do_arm();
    strb(0, 8'hFF); strb(0, 8'h00);
    chk("sat_notrig", triggered, 0); chk("sat_armed", armed, 1);
    do_abort();

    // abort on the firing strobe wins
    setcfg(1, 2'b00, 8'h80, 8'h10, 0, 0);
    do_arm();
    strb(0, 8'h60);
    abort = 1'b1; strb(0, 8'h85); abort = 1'b0;
    chk("ab_notrig", triggered, 0); chk("ab_idle", busy, 0);

    // abort beats arm in IDLE
    abort = 1'b1; arm = 1'b1; cyc(); abort = 1'b0; arm = 1'b0;
    chk("ab_arm", busy, 0);

    // arm while searching is ignored (no config recapture)
    setcfg(1, 2'b00, 8'h80, 8'h10, 0, 0);
    do_arm();
    tval = 8'h20; hyst = 8'h00;
    do_arm();
    strb(0, 8'h60); strb(0, 8'h85);
    chk("rearm_ign", triggered, 1);
    cyc();

    // reset in WAIT_EDGE discards the search
    setcfg(1, 2'b00, 8'h80, 8'h10, 0, 0);
    do_arm();
    strb(0, 8'h60);
    rst = 1'b1; strb(0, 8'h85);
    chk("rw_trig", triggered, 0); chk("rw_armed", armed, 0);
    chk("rw_busy", busy, 0); chk("rw_neg", trigger_neg, 0);
    rst = 1'b0; cyc();
    chk("rw_trig2", triggered, 0); chk("rw_busy2", busy, 0);
    do_arm();
    strb(0, 8'h60); strb(0, 8'h85);
    chk("rw_after", triggered, 1); chk("rw_after_neg", trigger_neg, 0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
